// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches 16-bit words over req/ack and presents decoded fields.
// Optional illegal-opcode trap with HALT is enabled by defining FETCH_ILLEGAL_TRAP_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [3:0]        rd,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [7:0]        imm,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_link,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_VALID = 2'd1,
        ST_FLUSH = 2'd2
`ifdef FETCH_ILLEGAL_TRAP_EN
        , ST_HALT = 2'd3
`endif
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] target_r;
    logic [15:0]       ir_r;
    logic [ADDR_W-1:0] pc_out_r;
    logic [ADDR_W-1:0] pc_link_r;
    logic              instr_valid_r;

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic              illegal_r;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op[3:1] == 3'b111);
    endfunction
`endif

    // Main fetch FSM with all presented outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            target_r      <= RESET_PC;
            ir_r          <= 16'h0000;
            pc_out_r      <= {ADDR_W{1'b0}};
            pc_link_r     <= PC_ONE;
            instr_valid_r <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            illegal_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            pc_r <= redirect_addr;
                        end else begin
                            // Request still outstanding: keep address stable, drop its data later.
                            target_r <= redirect_addr;
                            state_r  <= ST_FLUSH;
                        end
                    end else if (imem_ack) begin
                        ir_r          <= imem_rdata;
                        pc_out_r      <= pc_r;
                        pc_link_r     <= pc_r + PC_ONE;
                        pc_r          <= pc_r + PC_ONE;
                        instr_valid_r <= 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
                        illegal_r     <= is_illegal(imem_rdata[15:12]);
`endif
                        state_r       <= ST_VALID;
                    end
                end
                ST_FLUSH: begin
                    if (imem_ack) begin
                        pc_r    <= redirect ? redirect_addr : target_r;
                        state_r <= ST_REQ;
                    end else if (redirect) begin
                        target_r <= redirect_addr;
                    end
                end
                ST_VALID: begin
                    if (redirect) begin
                        instr_valid_r <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
                        illegal_r     <= 1'b0;
`endif
                        pc_r          <= redirect_addr;
                        state_r       <= ST_REQ;
                    end else if (instr_ready) begin
                        instr_valid_r <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
                        state_r       <= illegal_r ? ST_HALT : ST_REQ;
`else
                        state_r       <= ST_REQ;
`endif
                    end
                end
`ifdef FETCH_ILLEGAL_TRAP_EN
                ST_HALT: begin
                    instr_valid_r <= 1'b0;
                end
`endif
                default: begin
                    instr_valid_r <= 1'b0;
                    state_r       <= ST_REQ;
                end
            endcase
        end
    end

    // Request is gated by reset so it drops immediately when reset asserts.
    always_comb begin
        imem_req = 1'b0;
        if (rst && ((state_r == ST_REQ) || (state_r == ST_FLUSH))) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign opcode      = ir_r[15:12];
    assign rd          = ir_r[11:8];
    assign rs          = ir_r[7:4];
    assign rt          = ir_r[3:0];
    assign imm         = ir_r[7:0];
    assign pc_out      = pc_out_r;
    assign pc_link     = pc_link_r;
`ifdef FETCH_ILLEGAL_TRAP_EN
    assign illegal     = illegal_r;
`else
    assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, scoreboard queue, vector table and directed sequences.
module tb_fetch_unit;
    localparam int          AW  = 16;
    localparam logic [15:0] RPC = 16'h0010;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode, rd, rs, rt;
    logic [7:0]  imm;
    logic [15:0] pc_out, pc_link;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_addr(redirect_addr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .pc_out(pc_out), .pc_link(pc_link), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks after lat wait cycles, optional single-word override.
    int          lat = 0;
    int          cnt;
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_addr = 16'h0000;
    logic [15:0] ovr_data = 16'h0000;

    always_comb begin
        if (ovr_en && (imem_addr == ovr_addr)) imem_rdata = ovr_data;
        else imem_rdata = {1'b0, imem_addr[14:0] ^ 15'h2B6D};
    end
    assign imem_ack = imem_req && (cnt >= lat);

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 0;
        else if (imem_req && !imem_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: inputs are stable at negedge, so predict what the next edge does.
    typedef struct { logic [15:0] pc; logic [15:0] word; } exp_t;
    exp_t q[$];
    exp_t cur;
    bit   have = 1'b0;
    bit   discard = 1'b0;
    logic exp_ill;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            have = 1'b0;
            discard = 1'b0;
        end else begin
            if (instr_valid) begin
                if (!have) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_spurious_valid: actual pc_out=%0h required no instruction", pc_out);
                    end else begin
                        cur = q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
                    exp_ill = (cur.word[15:13] == 3'b111);
`else
                    exp_ill = 1'b0;
`endif
                    chk("sb_pc_out",  {16'h0, pc_out},  {16'h0, cur.pc});
                    chk("sb_pc_link", {16'h0, pc_link}, {16'h0, cur.pc + 16'h0001});
                    chk("sb_fields",  {16'h0, opcode, rd, rs, rt}, {16'h0, cur.word});
                    chk("sb_imm",     {24'h0, imm},     {24'h0, cur.word[7:0]});
                    chk("sb_illegal", {31'h0, illegal}, {31'h0, exp_ill});
                end
                if (instr_ready || redirect) have = 1'b0;
            end
            if (imem_req && imem_ack) begin
                if (redirect || discard) discard = 1'b0;
                else q.push_back('{pc: imem_addr, word: imem_rdata});
            end else if (imem_req && redirect) begin
                discard = 1'b1;
            end
        end
    end

    task automatic do_reset(input int l);
        rst = 1'b0;
        redirect = 1'b0;
        lat = l;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_valid(input logic [15:0] pc, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (instr_valid && (pc_out == pc)) found = 1'b1;
        end
        chk("wait_valid", {31'h0, found}, 32'h1);
    endtask

    task automatic pulse_redirect(input logic [15:0] a);
        redirect_addr = a;
        redirect = 1'b1;
        @(posedge clk);
        #1 redirect = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
        logic [3:0]  op, f_rd, f_rs, f_rt;
        logic [7:0]  f_imm;
        logic [15:0] link;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0030, 16'h1234, 4'h1, 4'h2, 4'h3, 4'h4, 8'h34, 16'h0031};
        vecs[1] = '{16'h0040, 16'h8A5F, 4'h8, 4'hA, 4'h5, 4'hF, 8'h5F, 16'h0041};
        vecs[2] = '{16'hFFFF, 16'h7FC0, 4'h7, 4'hF, 4'hC, 4'h0, 8'hC0, 16'h0000};
        vecs[3] = '{16'h1000, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 16'h1001};

        rst = 1'b0;
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        instr_ready = 1'b1;
        #2;
        chk("reset_req",   {31'h0, imem_req},    32'h0);
        chk("reset_valid", {31'h0, instr_valid}, 32'h0);
        chk("reset_pcout", {16'h0, pc_out},      32'h0);
        chk("reset_ill",   {31'h0, illegal},     32'h0);

        // 1: zero-wait streaming, one instruction every other cycle.
        do_reset(0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_valid", {31'h0, instr_valid}, (i % 2));
            chk("t1_req",   {31'h0, imem_req},    ((i + 1) % 2));
            if (i % 2 == 0) chk("t1_addr", {16'h0, imem_addr}, 32'h10 + i / 2);
            else chk("t1_link", {16'h0, pc_link}, 32'h11 + i / 2);
        end

        // 2: slow memory, downstream stalls.
        ovr_en = 1'b1; ovr_addr = 16'h0010; ovr_data = 16'h8A5F;
        instr_ready = 1'b0;
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_req_hold",  {31'h0, imem_req},  32'h1);
            chk("t2_addr_hold", {16'h0, imem_addr}, 32'h0010);
            chk("t2_no_valid",  {31'h0, instr_valid}, 32'h0);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_valid", {31'h0, instr_valid}, 32'h1);
            chk("t2_fields", {16'h0, opcode, rd, rs, rt}, 32'h8A5F);
            chk("t2_imm", {24'h0, imm}, 32'h5F);
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(negedge clk);
        chk("t2_still_valid", {31'h0, instr_valid}, 32'h1);
        @(negedge clk);
        chk("t2_accepted", {31'h0, instr_valid}, 32'h0);
        chk("t2_next_addr", {16'h0, imem_addr}, 32'h0011);
        ovr_en = 1'b0;

        // 3: redirect while a request is pending.
        do_reset(2);
        pulse_redirect(16'h0100);
        @(negedge clk);
        chk("t3_flush_req",  {31'h0, imem_req},  32'h1);
        chk("t3_flush_addr", {16'h0, imem_addr}, 32'h0010);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                chk("t3_no_valid", {31'h0, instr_valid}, 32'h0);
                if (imem_req && (imem_addr == 16'h0100)) seen = 1'b1;
            end
            chk("t3_target_req", {31'h0, seen}, 32'h1);
        end
        wait_valid(16'h0100, 10);

        // 4: redirect while holding a valid instruction.
        instr_ready = 1'b0;
        do_reset(0);
        wait_valid(16'h0010, 10);
        @(posedge clk);
        #1 redirect_addr = 16'h0200; redirect = 1'b1;
        @(negedge clk);
        chk("t4_valid_before", {31'h0, instr_valid}, 32'h1);
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("t4_valid_drop", {31'h0, instr_valid}, 32'h0);
        chk("t4_req",        {31'h0, imem_req},    32'h1);
        chk("t4_addr",       {16'h0, imem_addr},   32'h0200);

        // 5: PC wrap and asynchronous reset mid-request.
        instr_ready = 1'b1;
        do_reset(0);
        pulse_redirect(16'hFFFF);
        wait_valid(16'hFFFF, 10);
        chk("t5_link_wrap", {16'h0, pc_link}, 32'h0000);
        @(negedge clk);
        chk("t5_wrap_addr", {16'h0, imem_addr}, 32'h0000);
        chk("t5_wrap_req",  {31'h0, imem_req},  32'h1);
        lat = 4;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_req", {31'h0, imem_req}, 32'h0);
        chk("t5_async_pc",  {16'h0, imem_addr}, {16'h0, RPC});
        @(posedge clk);
        #1 rst = 1'b1; lat = 0;
        @(negedge clk);
        chk("t5_restart_req",  {31'h0, imem_req},  32'h1);
        chk("t5_restart_addr", {16'h0, imem_addr}, {16'h0, RPC});

        // Table of decode vectors reached via redirect.
        do_reset(0);
        for (int v = 0; v < 4; v++) begin
            @(posedge clk);
            #1 ovr_en = 1'b1; ovr_addr = vecs[v].addr; ovr_data = vecs[v].word;
            pulse_redirect(vecs[v].addr);
            wait_valid(vecs[v].addr, 10);
            chk("vec_op",   {28'h0, opcode},  {28'h0, vecs[v].op});
            chk("vec_rd",   {28'h0, rd},      {28'h0, vecs[v].f_rd});
            chk("vec_rs",   {28'h0, rs},      {28'h0, vecs[v].f_rs});
            chk("vec_rt",   {28'h0, rt},      {28'h0, vecs[v].f_rt});
            chk("vec_imm",  {24'h0, imm},     {24'h0, vecs[v].f_imm});
            chk("vec_link", {16'h0, pc_link}, {16'h0, vecs[v].link});
        end

        // 6: illegal opcode handling.
        ovr_en = 1'b1; ovr_addr = 16'h0300; ovr_data = 16'hE000;
        instr_ready = 1'b0;
        do_reset(0);
        pulse_redirect(16'h0300);
        wait_valid(16'h0300, 10);
        chk("t6_opcode", {28'h0, opcode}, 32'hE);
`ifdef FETCH_ILLEGAL_TRAP_EN
        chk("t6_illegal", {31'h0, illegal}, 32'h1);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 redirect_addr = 16'h0400; redirect = (i % 2 == 0);
            @(negedge clk);
            chk("t6_halt_req",   {31'h0, imem_req},    32'h0);
            chk("t6_halt_valid", {31'h0, instr_valid}, 32'h0);
            chk("t6_halt_ill",   {31'h0, illegal},     32'h1);
        end
        redirect = 1'b0;
`else
        chk("t6_illegal", {31'h0, illegal}, 32'h0);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_next_req",  {31'h0, imem_req},  32'h1);
        chk("t6_next_addr", {16'h0, imem_addr}, 32'h0301);
`endif
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
